// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited word requests, and buffers
// in-order responses with their PC for decode. Redirects flush everything still in flight.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_insn,
  output logic [31:0] out_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [31:0]   pc_reg;
  logic [CW-1:0] inflight_reg, drop_reg, count_reg;
  logic [PW-1:0] pq_head_reg, pq_tail_reg, buf_head_reg, buf_tail_reg;
  logic [31:0]   pq_mem [DEPTH];

  logic [DEPTH*32-1:0] buf_insn_flat, buf_pc_flat;

  logic req_fire, rsp_take, rsp_keep, pop;
  logic [31:0] head_insn, head_pc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) return '0;
    return p + PW'(1);
  endfunction

  always_comb begin
    imem_req_valid = !rst && !redirect_valid && ((inflight_reg + count_reg) < DEPTH_C);
    imem_req_addr  = pc_reg;
    req_fire       = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is stale and must not disturb the PC queue.
    rsp_take       = !rst && imem_rsp_valid && (inflight_reg != '0);
    rsp_keep       = rsp_take && (drop_reg == '0) && !redirect_valid;
    out_valid      = !rst && (count_reg != '0);
    pop            = out_valid && out_ready;
    head_insn      = buf_insn_flat[int'(buf_head_reg)*32 +: 32];
    head_pc        = buf_pc_flat[int'(buf_head_reg)*32 +: 32];
    out_insn       = out_valid ? head_insn : 32'h0;
    out_pc         = out_valid ? head_pc : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (req_fire) pq_mem[pq_tail_reg] <= pc_reg;
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_buf
      logic [31:0] insn_reg, pc_reg_e;
      always_ff @(posedge clk) begin
        if (rsp_keep && (buf_tail_reg == PW'(gi))) begin
          insn_reg <= imem_rsp_data;
          pc_reg_e <= pq_mem[pq_head_reg];
        end
      end
      assign buf_insn_flat[gi*32 +: 32] = insn_reg;
      assign buf_pc_flat[gi*32 +: 32]   = pc_reg_e;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg       <= RESET_PC;
      inflight_reg <= '0;
      drop_reg     <= '0;
      count_reg    <= '0;
      pq_head_reg  <= '0;
      pq_tail_reg  <= '0;
      buf_head_reg <= '0;
      buf_tail_reg <= '0;
    end else begin
      if (req_fire) begin
        pc_reg      <= pc_reg + 32'd4;
        pq_tail_reg <= ptr_inc(pq_tail_reg);
      end
      if (rsp_take) pq_head_reg <= ptr_inc(pq_head_reg);
      inflight_reg <= inflight_reg + CW'(req_fire) - CW'(rsp_take);

      if (redirect_valid) begin
        // Everything still outstanding after this cycle belongs to the old path.
        pc_reg       <= {redirect_pc[31:2], 2'b00};
        drop_reg     <= inflight_reg - CW'(rsp_take);
        count_reg    <= '0;
        buf_head_reg <= '0;
        buf_tail_reg <= '0;
      end else begin
        if (rsp_take && (drop_reg != '0)) drop_reg <= drop_reg - CW'(1);
        if (rsp_keep) buf_tail_reg <= ptr_inc(buf_tail_reg);
        if (pop) buf_head_reg <= ptr_inc(buf_head_reg);
        count_reg <= count_reg + CW'(rsp_keep) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: in-order memory model with adjustable latency, an output
// monitor tracking the expected fetch sequence, and cycle-exact checks per scenario.
module tb_ifetch;
  logic        clk = 0;
  logic        rst = 1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_insn, out_pc;

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;
  int n_req    = 0;
  int mem_wait = 0;
  logic [31:0] exp_pc = 32'h0;

  ifetch #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_insn(out_insn), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return 32'h14d2_8393 + a;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  // Instruction memory: answers requests in order, mem_wait extra cycles after acceptance.
  initial begin
    logic [31:0] qa[$];
    int          qg[$];
    logic        f, consumed, r;
    logic [31:0] fa;
    imem_rsp_valid = 0;
    imem_rsp_data  = 0;
    forever begin
      @(negedge clk);
      f        = !rst && imem_req_valid && imem_req_ready;
      fa       = imem_req_addr;
      consumed = imem_rsp_valid;
      r        = rst;
      @(posedge clk); #1;
      if (r) begin
        qa.delete();
        qg.delete();
      end else begin
        if (consumed && qa.size() > 0) begin
          void'(qa.pop_front());
          void'(qg.pop_front());
        end
        foreach (qg[i]) qg[i]++;
        if (f) begin
          qa.push_back(fa);
          qg.push_back(0);
        end
      end
      if (qa.size() > 0 && qg[0] >= mem_wait) begin
        imem_rsp_valid = 1;
        imem_rsp_data  = mdata(qa[0]);
      end else begin
        imem_rsp_valid = 0;
        imem_rsp_data  = 0;
      end
    end
  end

  // Output monitor: every transfer must continue the expected sequential PC stream.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) n_req = 0;
      else if (imem_req_valid && imem_req_ready) n_req++;
      if (!rst && out_valid && out_ready) begin
        $display("xfer pc=%h insn=%h", out_pc, out_insn);
        check("xfer_pc", out_pc, exp_pc);
        check("xfer_insn", out_insn, mdata(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_xfer++;
      end
    end
  end

  task automatic do_reset();
    step();
    rst = 1;
    redirect_valid = 0;
    exp_pc = 32'h0;
    look();
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_insn", out_insn, 32'h0);
    step();
    rst = 0;
    look();
  endtask

  task automatic wait_xfers(input string tag, input int n);
    int base;
    int k;
    base = n_xfer;
    k = 0;
    while (n_xfer < base + n && k < 30) begin
      step();
      look();
      k++;
    end
    check(tag, (n_xfer - base >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    imem_req_ready = 1;
    out_ready      = 1;
    redirect_valid = 0;
    redirect_pc    = 0;

    // 1: streaming fetch with single-cycle memory
    do_reset();
    check("t1_c0_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("t1_c0_addr", imem_req_addr, 32'h0);
    check("t1_c0_out_valid", {31'b0, out_valid}, 32'd0);
    step(); look();
    check("t1_c1_out_valid", {31'b0, out_valid}, 32'd0);
    check("t1_c1_addr", imem_req_addr, 32'h4);
    step(); look();
    check("t1_c2_out_valid", {31'b0, out_valid}, 32'd1);
    check("t1_c2_out_pc", out_pc, 32'h0);
    check("t1_c2_out_insn", out_insn, 32'h14d2_8393);
    check("t1_c2_req_valid", {31'b0, imem_req_valid}, 32'd0);
    step(); look();
    check("t1_c3_out_pc", out_pc, 32'h4);
    check("t1_c3_addr", imem_req_addr, 32'h8);
    wait_xfers("t1_stream", 4);

    // 2: decode stalled; credit caps accepted requests at DEPTH
    out_ready = 0;
    do_reset();
    step(); look();
    step(); look();
    check("t2_c2_req_valid", {31'b0, imem_req_valid}, 32'd0);
    step(); look();
    check("t2_c3_out_valid", {31'b0, out_valid}, 32'd1);
    check("t2_c3_out_pc", out_pc, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(); look();
      check("t2_hold_pc", out_pc, 32'h0);
      check("t2_hold_insn", out_insn, mdata(32'h0));
      check("t2_hold_req_valid", {31'b0, imem_req_valid}, 32'd0);
    end
    step();
    check("t2_req_count", n_req, 32'd2);
    out_ready = 1;
    look();
    check("t2_c8_out_pc", out_pc, 32'h0);
    step(); look();
    check("t2_c9_out_pc", out_pc, 32'h4);
    check("t2_c9_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("t2_c9_addr", imem_req_addr, 32'h8);
    wait_xfers("t2_resume", 2);

    // 3: redirect with two requests in flight on a slow memory
    mem_wait = 3;
    do_reset();
    step(); look();
    step();
    redirect_valid = 1;
    redirect_pc = 32'h100;
    exp_pc = 32'h100;
    look();
    check("t3_redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
    step();
    redirect_valid = 0;
    look();
    check("t3_c3_addr", imem_req_addr, 32'h100);
    check("t3_c3_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("t3_c3_out_valid", {31'b0, out_valid}, 32'd0);
    step(); look();
    step(); look();
    check("t3_c5_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("t3_c5_addr", imem_req_addr, 32'h100);
    check("t3_c5_out_valid", {31'b0, out_valid}, 32'd0);
    step(); look();
    check("t3_c6_out_valid", {31'b0, out_valid}, 32'd0);
    wait_xfers("t3_first_out", 1);
    mem_wait = 0;

    // 4: misaligned redirect coincident with a response
    do_reset();
    step();
    redirect_valid = 1;
    redirect_pc = 32'h203;
    exp_pc = 32'h200;
    look();
    check("t4_redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
    step();
    redirect_valid = 0;
    look();
    check("t4_c2_addr", imem_req_addr, 32'h200);
    check("t4_c2_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("t4_c2_out_valid", {31'b0, out_valid}, 32'd0);
    step(); look();
    check("t4_c3_out_valid", {31'b0, out_valid}, 32'd0);
    step(); look();
    check("t4_c4_out_valid", {31'b0, out_valid}, 32'd1);
    check("t4_c4_out_pc", out_pc, 32'h200);

    // PC wraps past the top of the address space
    do_reset();
    step();
    redirect_valid = 1;
    redirect_pc = 32'hFFFF_FFFE;
    exp_pc = 32'hFFFF_FFFC;
    look();
    step();
    redirect_valid = 0;
    look();
    check("wrap_c2_addr", imem_req_addr, 32'hFFFF_FFFC);
    step(); look();
    check("wrap_c3_addr", imem_req_addr, 32'h0);
    check("wrap_c3_req_valid", {31'b0, imem_req_valid}, 32'd1);
    step(); look();
    check("wrap_c4_out_pc", out_pc, 32'hFFFF_FFFC);

    // 5: memory not ready for five cycles
    imem_req_ready = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_addr", imem_req_addr, 32'h0);
      check("t5_hold_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check("t5_hold_out_valid", {31'b0, out_valid}, 32'd0);
      if (i < 4) begin
        step(); look();
      end
    end
    step();
    imem_req_ready = 1;
    look();
    check("t5_c5_addr", imem_req_addr, 32'h0);
    step(); look();
    check("t5_c6_addr", imem_req_addr, 32'h4);

    // 6: reset with one in flight and one buffered
    out_ready = 0;
    do_reset();
    step(); look();
    step();
    rst = 1;
    look();
    check("t6_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("t6_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    step();
    rst = 0;
    exp_pc = 32'h0;
    look();
    check("t6_c3_out_valid", {31'b0, out_valid}, 32'd0);
    check("t6_c3_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("t6_c3_addr", imem_req_addr, 32'h0);
    out_ready = 1;
    wait_xfers("t6_restart", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
